// File: rtl/rs422_ctrl_pkg.sv
// Shared types and helpers for the RS-422/RS-485 direction controller.
package rs422_ctrl_pkg;

  typedef enum logic [1:0] {
    RX   = 2'd0,
    LEAD = 2'd1,
    TX   = 2'd2,
    TAIL = 2'd3
  } dir_state_t;

  // Guard counter width: enough for the longer guard time, never zero bits.
  function automatic int unsigned cnt_width(input int unsigned lead, input int unsigned tail);
    int unsigned m;
    m = (lead > tail) ? lead : tail;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rs422_dir_chan.sv
// One transceiver channel: direction FSM with lead/tail guard counter.
module rs422_dir_chan
  import rs422_ctrl_pkg::*;
#(
  parameter int unsigned LEAD_CYCLES = 16,
  parameter int unsigned TAIL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_full_duplex_i,
  input  logic       cfg_term_i,
  input  logic       tx_req_i,
  input  logic       tx_busy_i,
  output logic       tx_grant_o,
  output logic       de_o,
  output logic       re_n_o,
  output logic       te_o,
  output logic [1:0] state_o
);

  localparam int unsigned CW = cnt_width(LEAD_CYCLES, TAIL_CYCLES);
  localparam logic [CW-1:0] LEAD_LOAD = (LEAD_CYCLES > 0) ? CW'(LEAD_CYCLES - 1) : '0;
  localparam logic [CW-1:0] TAIL_LOAD = (TAIL_CYCLES > 0) ? CW'(TAIL_CYCLES - 1) : '0;

  dir_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fd_q, fd_d;
  logic          grant_q, grant_d;
  logic          de_q, de_d;
  logic          re_n_q, re_n_d;
  logic          te_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fd_d    = fd_q;
    case (state_q)
      RX: begin
        fd_d = cfg_full_duplex_i;
        if (cfg_full_duplex_i) begin
          state_d = TX;
        end else if (tx_req_i) begin
          if (LEAD_CYCLES == 0) begin
            state_d = TX;
          end else begin
            state_d = LEAD;
            cnt_d   = LEAD_LOAD;
          end
        end
      end
      LEAD: begin
        if (!tx_req_i) begin
          state_d = (TAIL_CYCLES == 0) ? RX : TAIL;
          cnt_d   = TAIL_LOAD;
        end else if (cnt_q == '0) begin
          state_d = TX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TX: begin
        if (fd_q) begin
          // Full duplex drains the UART before releasing the line.
          if (!cfg_full_duplex_i && !tx_busy_i) state_d = RX;
        end else if (cfg_full_duplex_i) begin
          fd_d = 1'b1;
        end else if (!tx_req_i && !tx_busy_i) begin
          state_d = (TAIL_CYCLES == 0) ? RX : TAIL;
          cnt_d   = TAIL_LOAD;
        end
      end
      TAIL: begin
        if (tx_req_i) begin
          // Driver is still on, so a new request skips the lead phase.
          state_d = TX;
          cnt_d   = '0;
          fd_d    = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = RX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RX;
    endcase
  end

  // Outputs are registered from the next state so they change with it.
  always_comb begin
    de_d    = (state_d != RX);
    re_n_d  = (state_d != RX) && !((state_d == TX) && fd_d);
    grant_d = (state_q == TX) && (state_d == TX) && tx_req_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      grant_q <= 1'b0;
      de_q    <= 1'b0;
      re_n_q  <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      grant_q <= grant_d;
      de_q    <= de_d;
      re_n_q  <= re_n_d;
      te_q    <= cfg_term_i;
    end
  end

  assign tx_grant_o = grant_q;
  assign de_o       = de_q;
  assign re_n_o     = re_n_q;
  assign te_o       = te_q;
  assign state_o    = state_q;

endmodule

// File: rtl/rs422_dir_ctrl.sv
// Multi-channel transceiver direction control; one independent FSM per channel.
module rs422_dir_ctrl #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned LEAD_CYCLES = 16,
  parameter int unsigned TAIL_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   cfg_full_duplex,
  input  logic [CHANNELS-1:0]   cfg_term,
  input  logic [CHANNELS-1:0]   tx_req,
  input  logic [CHANNELS-1:0]   tx_busy,
  output logic [CHANNELS-1:0]   tx_grant,
  output logic [CHANNELS-1:0]   rs422_de,
  output logic [CHANNELS-1:0]   rs422_re_n,
  output logic [CHANNELS-1:0]   rs422_te,
  output logic [2*CHANNELS-1:0] chan_state
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    rs422_dir_chan #(
      .LEAD_CYCLES(LEAD_CYCLES),
      .TAIL_CYCLES(TAIL_CYCLES)
    ) u_chan (
      .clk              (clk),
      .reset_n          (reset_n),
      .cfg_full_duplex_i(cfg_full_duplex[g]),
      .cfg_term_i       (cfg_term[g]),
      .tx_req_i         (tx_req[g]),
      .tx_busy_i        (tx_busy[g]),
      .tx_grant_o       (tx_grant[g]),
      .de_o             (rs422_de[g]),
      .re_n_o           (rs422_re_n[g]),
      .te_o             (rs422_te[g]),
      .state_o          (chan_state[2*g +: 2])
    );
  end

endmodule
